sram_port_arbiter: RTL and testbench

Shares the single SRAM_Controller core port between the gesture datapath's requesters: point capture (record/runtest), resample writeback, and the similarity library fetch. Accepts one access request per requester, grants round-robin, and sequences one transaction at a time through the controller's request/wait handshake. Returns read data and a completion pulse to the winner, and aborts accesses that stall with an error. It sits between the recognition top-level sequencer and SRAM_Controller.

---
 rtl/sram_port_arbiter_pkg.sv | 17 +
 rtl/sram_port_arbiter_if.sv | 38 +++
 rtl/rr_pick.sv | 26 ++
 rtl/sram_port_arbiter.sv | 95 +++++++++
 tb/tb_sram_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the SRAM port arbiter and its requesters.
// AW/DW defaults must stay aligned with SRAM_Controller.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

    localparam int REQ_CAPTURE  = 0;
    localparam int REQ_RESAMPLE = 1;
    localparam int REQ_SIM      = 2;

    localparam int N_REQ_DEF   = 3;
    localparam int AW_DEF      = 20;
    localparam int DW_DEF      = 16;
    localparam int TIMEOUT_DEF = 255;
    localparam int OWNER_W     = 2;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and controller-side signals of the SRAM port arbiter.
// The arbiter uses the slave view; whoever drives requests and the controller uses master.
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
);
    logic [N_REQ-1:0]    i_req;
    logic [N_REQ-1:0]    i_wr;
    logic [N_REQ-1:0]    i_lock;
    logic [N_REQ*AW-1:0] i_addr;
    logic [N_REQ*DW-1:0] i_wdata;
    logic [N_REQ-1:0]    o_ack;
    logic [N_REQ-1:0]    o_err;
    logic [DW-1:0]       o_rdata;
    logic                o_mem_req;
    logic                o_mem_wr;
    logic [AW-1:0]       o_mem_addr;
    logic [DW-1:0]       o_mem_wdata;
    logic                i_mem_wait;
    logic [DW-1:0]       i_mem_rdata;
    logic                o_busy;
    logic [OWNER_W-1:0]  o_owner;

    modport slave (
        input  i_req, i_wr, i_lock, i_addr, i_wdata, i_mem_wait, i_mem_rdata,
        output o_ack, o_err, o_rdata, o_mem_req, o_mem_wr, o_mem_addr, o_mem_wdata,
               o_busy, o_owner
    );

    modport master (
        output i_req, i_wr, i_lock, i_addr, i_wdata, i_mem_wait, i_mem_rdata,
        input  o_ack, o_err, o_rdata, o_mem_req, o_mem_wr, o_mem_addr, o_mem_wdata,
               o_busy, o_owner
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    // Rotating a doubled copy puts requester ptr at bit 0.
    logic [2*N_REQ-1:0] dbl;
    assign dbl = {req, req} >> ptr;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (dbl[off]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(ptr) + off) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing the SRAM_Controller core port between the gesture requesters.
// One transaction in flight; stalled accesses abort after TIMEOUT wait cycles.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    sram_port_arbiter_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] own;
    logic [CNT_W-1:0] stall_cnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (bus.i_req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            own             <= '0;
            stall_cnt       <= '0;
            bus.o_ack       <= '0;
            bus.o_err       <= '0;
            bus.o_rdata     <= '0;
            bus.o_mem_req   <= 1'b0;
            bus.o_mem_wr    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            bus.o_busy      <= 1'b0;
            bus.o_owner     <= '0;
        end else begin
            bus.o_ack <= '0;
            bus.o_err <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        own             <= pick_idx;
                        bus.o_owner     <= OWNER_W'(pick_idx);
                        bus.o_mem_req   <= 1'b1;
                        bus.o_mem_wr    <= bus.i_wr[pick_idx];
                        bus.o_mem_addr  <= bus.i_addr[int'(pick_idx)*AW +: AW];
                        bus.o_mem_wdata <= bus.i_wdata[int'(pick_idx)*DW +: DW];
                        bus.o_busy      <= 1'b1;
                        stall_cnt       <= '0;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.i_mem_wait) begin
                        bus.o_mem_req  <= 1'b0;
                        bus.o_rdata    <= bus.o_mem_wr ? '0 : bus.i_mem_rdata;
                        bus.o_ack[own] <= 1'b1;
                        state          <= RESP;
                    end else if (stall_cnt == CNT_LAST) begin
                        // This is the TIMEOUT-th stalled cycle: abandon the access.
                        bus.o_mem_req  <= 1'b0;
                        bus.o_rdata    <= '0;
                        bus.o_ack[own] <= 1'b1;
                        bus.o_err[own] <= 1'b1;
                        state          <= RESP;
                    end else if (stall_cnt != CNT_MAX) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.i_lock[own])
                        ptr <= own;
                    else
                        ptr <= (int'(own) == N_REQ - 1) ? '0 : own + 1'b1;
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter and its rr_pick picker.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int N = 3, AW = 20, DW = 16, TO = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();
    sram_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    // Controller read data is a keyed function of the presented address.
    logic [DW-1:0] key = 16'h5A3C;
    assign bus.i_mem_rdata = bus.o_mem_addr[DW-1:0] ^ key;

    logic [N-1:0] pk_req;
    logic [1:0]   pk_ptr, pk_idx;
    logic         pk_found;
    rr_pick #(.N_REQ(N), .IDX_W(2)) u_pk (.req(pk_req), .ptr(pk_ptr), .idx(pk_idx), .found(pk_found));

    int checks = 0, errors = 0;

    function automatic int ref_pick(logic [N-1:0] r, int p);
        for (int o = 0; o < N; o++) if (r[(p + o) % N]) return (p + o) % N;
        return -1;
    endfunction

    function automatic logic [AW-1:0] get_addr(int k);
        return bus.i_addr[k*AW +: AW];
    endfunction

    task automatic clear_inputs();
        bus.i_req = '0; bus.i_wr = '0; bus.i_lock = '0;
        bus.i_addr = '0; bus.i_wdata = '0; bus.i_mem_wait = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rr_pick();
        int e;
        for (int i = 0; i < 40; i++) begin
            pk_req = N'($urandom);
            pk_ptr = 2'($urandom_range(0, N - 1));
            #1;
            e = ref_pick(pk_req, int'(pk_ptr));
            checks++;
            if (pk_found !== (e >= 0) || (e >= 0 && pk_idx !== e[1:0])) begin
                errors++;
                $display("FAIL rr_pick req=%b ptr=%0d: got found=%b idx=%0d want %0d", pk_req, pk_ptr, pk_found, pk_idx, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_mem_req, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata, bus.o_ack, bus.o_err,
             bus.o_rdata, bus.o_busy, bus.o_owner} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b ack=%b busy=%b owner=%0d, want all 0", bus.o_mem_req, bus.o_ack, bus.o_busy, bus.o_owner);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        apply_reset();
        bus.i_req[REQ_RESAMPLE] = 1'b1;
        bus.i_addr[REQ_RESAMPLE*AW +: AW] = 20'h00403;
        @(negedge clk);
        checks++;
        if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 20'h00403 || bus.o_mem_wr !== 1'b0 ||
            bus.o_owner !== 2'd1 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got req=%b addr=%h owner=%0d busy=%b, want 1 00403 1 1", bus.o_mem_req, bus.o_mem_addr, bus.o_owner, bus.o_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.o_ack !== 3'b010 || bus.o_err !== 3'b000 || bus.o_rdata !== (16'h0403 ^ key)) begin
            errors++;
            $display("FAIL single_ack: got ack=%b err=%b rdata=%h, want 010 000 %h", bus.o_ack, bus.o_err, bus.o_rdata, 16'h0403 ^ key);
        end
        bus.i_req = '0;
        @(negedge clk);
        checks++;
        if (bus.o_ack !== 3'b000 || bus.o_busy !== 1'b0 || bus.o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got ack=%b busy=%b req=%b, want 000 0 0", bus.o_ack, bus.o_busy, bus.o_mem_req);
        end
    endtask

    task automatic test_round_robin();
        int ptr_m, last, n, w;
        apply_reset();
        key = 16'($urandom);
        bus.i_req = '1;
        for (int k = 0; k < N; k++) bus.i_addr[k*AW +: AW] = AW'($urandom);
        ptr_m = 0; last = 0; n = 0;
        for (int c = 1; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (bus.o_ack !== '0) begin
                w = ref_pick('1, ptr_m);
                checks++;
                if (bus.o_ack !== (3'b001 << w) || bus.o_rdata !== (get_addr(w)[DW-1:0] ^ key)) begin
                    errors++;
                    $display("FAIL rr_order #%0d: got ack=%b rdata=%h, want owner %0d rdata %h", n, bus.o_ack, bus.o_rdata, w, get_addr(w)[DW-1:0] ^ key);
                end
                checks++;
                if (c != ((n == 0) ? 2 : last + 3)) begin
                    errors++;
                    $display("FAIL rr_period #%0d: got cycle %0d, want %0d", n, c, (n == 0) ? 2 : last + 3);
                end
                ptr_m = (w + 1) % N; last = c; n++;
                bus.i_addr[w*AW +: AW] = AW'($urandom);
            end
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL rr_count: got %0d acks, want 6", n); end
        bus.i_req = '0;
    endtask

    task automatic test_lock();
        logic [4:0] letter;
        logic [AW-1:0] a0, exp_a;
        int n, last;
        apply_reset();
        key = 16'($urandom);
        letter = 5'($urandom);
        a0 = AW'($urandom);
        bus.i_req[REQ_SIM] = 1'b1; bus.i_lock[REQ_SIM] = 1'b1;
        bus.i_addr[REQ_SIM*AW +: AW] = {5'd0, letter, 6'd0, 4'd0};
        @(negedge clk);
        bus.i_req[REQ_CAPTURE] = 1'b1;
        bus.i_addr[REQ_CAPTURE*AW +: AW] = a0;
        n = 0; last = 0;
        for (int c = 2; c < 100 && n < 17; c++) begin
            @(negedge clk);
            if (bus.o_ack !== '0) begin
                exp_a = (n < 16) ? {5'd0, letter, 6'd0, 4'(n)} : a0;
                checks++;
                if (bus.o_ack !== ((n < 16) ? 3'b100 : 3'b001) || bus.o_rdata !== (exp_a[DW-1:0] ^ key)) begin
                    errors++;
                    $display("FAIL lock_burst #%0d: got ack=%b rdata=%h, want owner %0d rdata %h", n, bus.o_ack, bus.o_rdata, (n < 16) ? 2 : 0, exp_a[DW-1:0] ^ key);
                end
                checks++;
                if (n > 0 && c != last + 3) begin
                    errors++;
                    $display("FAIL lock_period #%0d: got cycle %0d, want %0d", n, c, last + 3);
                end
                if (n < 15) bus.i_addr[REQ_SIM*AW +: AW] = {5'd0, letter, 6'd0, 4'(n + 1)};
                else if (n == 15) begin bus.i_lock = '0; bus.i_req[REQ_SIM] = 1'b0; end
                else bus.i_req = '0;
                last = c; n++;
            end
        end
        checks++;
        if (n != 17) begin errors++; $display("FAIL lock_count: got %0d acks, want 17", n); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        int hi;
        bit got;
        apply_reset();
        bus.i_mem_wait = 1'b1;
        bus.i_req[REQ_RESAMPLE] = 1'b1;
        bus.i_addr[REQ_RESAMPLE*AW +: AW] = AW'($urandom);
        hi = 0; got = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (bus.o_mem_req === 1'b1) hi++;
            if (bus.o_ack !== '0 && !got) begin
                got = 1;
                checks++;
                if (bus.o_ack !== 3'b010 || bus.o_err !== 3'b010 || bus.o_rdata !== '0 || bus.o_mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_resp: got ack=%b err=%b rdata=%h req=%b, want 010 010 0000 0", bus.o_ack, bus.o_err, bus.o_rdata, bus.o_mem_req);
                end
                checks++;
                if (hi != TO) begin errors++; $display("FAIL timeout_len: got %0d stalled cycles, want %0d", hi, TO); end
                bus.i_req = '0;
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL timeout_ack: got no ack within 300 cycles, want one"); end
        bus.i_mem_wait = 1'b0;
    endtask

    task automatic test_write_hold();
        logic [AW-1:0] a;
        apply_reset();
        a = AW'($urandom);
        bus.i_req[REQ_CAPTURE] = 1'b1; bus.i_wr[REQ_CAPTURE] = 1'b1;
        bus.i_addr[REQ_CAPTURE*AW +: AW] = a;
        bus.i_wdata[REQ_CAPTURE*DW +: DW] = 16'h0A0B;
        bus.i_mem_wait = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_mem_req !== 1'b1 || bus.o_mem_wr !== 1'b1 || bus.o_mem_addr !== a ||
                bus.o_mem_wdata !== 16'h0A0B || bus.o_ack !== '0) begin
                errors++;
                $display("FAIL write_hold c%0d: got req=%b wr=%b addr=%h wdata=%h ack=%b, want 1 1 %h 0a0b 000", c, bus.o_mem_req, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata, bus.o_ack, a);
            end
            if (c == 1) begin
                bus.i_addr[REQ_CAPTURE*AW +: AW] = ~a;
                bus.i_wdata[REQ_CAPTURE*DW +: DW] = 16'($urandom);
            end
            if (c == 5) bus.i_mem_wait = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (bus.o_ack !== 3'b001 || bus.o_err !== '0 || bus.o_rdata !== '0 || bus.o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL write_ack: got ack=%b err=%b rdata=%h req=%b, want 001 000 0000 0", bus.o_ack, bus.o_err, bus.o_rdata, bus.o_mem_req);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_issue();
        apply_reset();
        bus.i_mem_wait = 1'b1;
        bus.i_req[REQ_SIM] = 1'b1;
        bus.i_addr[REQ_SIM*AW +: AW] = AW'($urandom);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_mem_req, bus.o_mem_addr, bus.o_ack, bus.o_err, bus.o_rdata, bus.o_busy, bus.o_owner} !== '0) begin
            errors++;
            $display("FAIL reset_async: got req=%b busy=%b owner=%0d, want all 0", bus.o_mem_req, bus.o_busy, bus.o_owner);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_req = '1;
        bus.i_mem_wait = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_mem_req !== 1'b1 || bus.o_owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_ptr: got req=%b owner=%0d, want 1 0", bus.o_mem_req, bus.o_owner);
        end
        @(negedge clk);
        checks++;
        if (bus.o_ack !== 3'b001) begin errors++; $display("FAIL reset_first_ack: got %b, want 001", bus.o_ack); end
        clear_inputs();
    endtask

    // Random traffic scored against a cycle-arithmetic model of grants and completions.
    task automatic test_random();
        int g, s, w, ack_at, next_free, ptr_m;
        logic [N-1:0] pend, exp_ack;
        logic gwr, exp_mr;
        logic [AW-1:0] gaddr;
        logic [DW-1:0] gwd, exp_rd;
        apply_reset();
        key = 16'($urandom);
        pend = '0; ptr_m = 0; next_free = 0; ack_at = -1; g = -10; s = 0; w = 0;
        gwr = 0; gaddr = '0; gwd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clk);
            exp_mr = (cyc > g && cyc <= g + s + 1);
            checks++;
            if (bus.o_mem_req !== exp_mr || (exp_mr && {bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata} !== {gwr, gaddr, gwd})) begin
                errors++;
                $display("FAIL rand_mem c%0d: got req=%b wr=%b addr=%h wd=%h, want %b %b %h %h", cyc, bus.o_mem_req, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata, exp_mr, gwr, gaddr, gwd);
            end
            exp_ack = (cyc == ack_at) ? (3'b001 << w) : 3'b000;
            exp_rd = gwr ? '0 : (gaddr[DW-1:0] ^ key);
            checks++;
            if (bus.o_ack !== exp_ack || bus.o_err !== '0 ||
                (cyc == ack_at && (bus.o_rdata !== exp_rd || bus.o_owner !== 2'(w)))) begin
                errors++;
                $display("FAIL rand_ack c%0d: got ack=%b err=%b rdata=%h owner=%0d, want %b 000 %h %0d", cyc, bus.o_ack, bus.o_err, bus.o_rdata, bus.o_owner, exp_ack, exp_rd, w);
            end
            for (int k = 0; k < N; k++) begin
                bus.i_wr[k] = 1'($urandom);
                bus.i_addr[k*AW +: AW] = AW'($urandom);
                bus.i_wdata[k*DW +: DW] = DW'($urandom);
                if (cyc > g && cyc < ack_at && k == w) pend[k] = 1'b1;
                else if (cyc == ack_at && k == w) pend[k] = 1'($urandom);
                else if (pend[k]) pend[k] = ($urandom_range(0, 7) != 0);
                else pend[k] = 1'($urandom);
            end
            bus.i_lock = N'($urandom);
            if (cyc == ack_at) ptr_m = bus.i_lock[w] ? w : (w + 1) % N;
            bus.i_req = pend;
            if (cyc > g && cyc <= g + s) bus.i_mem_wait = 1'b1;
            else if (cyc == g + s + 1) bus.i_mem_wait = 1'b0;
            else bus.i_mem_wait = 1'($urandom);
            if (cyc >= next_free && pend != '0) begin
                w = ref_pick(pend, ptr_m);
                g = cyc; s = $urandom_range(0, 3);
                gwr = bus.i_wr[w]; gaddr = get_addr(w); gwd = bus.i_wdata[w*DW +: DW];
                ack_at = g + s + 2; next_free = ack_at + 1;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_rr_pick();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_timeout();
        test_write_hold();
        test_reset_mid_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
